// File: rtl/seq_coef_mult_pkg.sv
// seq_coef_mult_pkg: shared state encoding and default coefficient set for seq_coef_mult.
package seq_coef_mult_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_OUT} state_t;
  localparam logic [15:0] DEF_COEFS = {4'd8, 4'd7, 4'd3, 4'd1};
endpackage

// File: rtl/seq_coef_mult_sa_mult_core.sv
// sa_mult_core: bit-serial shift-add datapath; one coefficient bit per step.
module sa_mult_core #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic             step,
  input  logic [DW-1:0]    d,
  input  logic [CW-1:0]    coef,
  output logic             done,
  output logic [DW+CW-1:0] res
);
  localparam int BW = CW > 1 ? $clog2(CW) : 1;
  logic [DW-1:0]    d_reg_q;
  logic [DW+CW-1:0] acc_q;
  logic [BW-1:0]    bit_cnt_q;
  assign done = bit_cnt_q == BW'(CW - 1);
  // res is the accumulator including the current bit, so the last step's sum is the product
  assign res  = acc_q + (coef[bit_cnt_q] ? ({{CW{1'b0}}, d_reg_q} << bit_cnt_q) : '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_reg_q   <= '0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
    end else if (start) begin
      d_reg_q   <= d;
      acc_q     <= '0;
      bit_cnt_q <= '0;
    end else if (clr) begin
      acc_q     <= '0;
      bit_cnt_q <= '0;
    end else if (step) begin
      acc_q     <= res;
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/seq_coef_mult.sv
// seq_coef_mult: streams d*COEF[i] for every coefficient, computed bit-serially, valid/ready on both sides.
module seq_coef_mult
  import seq_coef_mult_pkg::*;
#(
  parameter int                   DW    = 8,
  parameter int                   CW    = 4,
  parameter int                   NCOEF = 4,
  parameter logic [NCOEF*CW-1:0]  COEFS = DEF_COEFS,
  localparam int                  OW    = DW + CW,
  localparam int                  IW    = NCOEF > 1 ? $clog2(NCOEF) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out,
  output logic [IW-1:0] out_idx,
  output logic          out_last
);
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, out_idx_q, out_idx_d;
  logic [OW-1:0] out_q, out_d, res;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          start, clr, step, done;
  sa_mult_core #(.DW(DW), .CW(CW)) u_core (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .clr  (clr),
    .step (step),
    .d    (d),
    .coef (COEFS[idx_q*CW +: CW]),
    .done (done),
    .res  (res)
  );
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    start       = 1'b0;
    clr         = 1'b0;
    step        = 1'b0;
    case (state_q)
      ST_IDLE: if (in_valid && in_ready_q) begin
        start      = 1'b1;
        idx_d      = '0;
        in_ready_d = 1'b0;
        state_d    = ST_CALC;
      end
      ST_CALC: begin
        step = 1'b1;
        if (done) begin
          out_d       = res;
          out_idx_d   = idx_q;
          out_last_d  = idx_q == IW'(NCOEF - 1);
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        if (out_last_q) begin
          in_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          clr     = 1'b1;
          state_d = ST_CALC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_seq_coef_mult.sv
// tb_seq_coef_mult: directed plus random samples checked against d*coef products and cycle timing.
module tb_seq_coef_mult;
  logic        clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0]  d;
  logic [11:0] out;
  logic [1:0]  out_idx;
  logic        v2, ir2, ov2, or2, ol2;
  logic [7:0]  d2;
  logic [11:0] o2;
  logic [0:0]  oi2;
  int total, bad, cyc;
  int coef [4] = '{1, 3, 7, 8};
  seq_coef_mult dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_idx(out_idx), .out_last(out_last)
  );
  seq_coef_mult #(.NCOEF(2), .COEFS({4'd15, 4'd0})) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .d(d2),
    .out_valid(ov2), .out_ready(or2), .out(o2), .out_idx(oi2), .out_last(ol2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic run_sample(input logic [7:0] dv, input int stall_idx, input int stall_n, input bit churn);
    int a, t, stalled;
    stalled = 0;
    chk("in_ready_pre", in_ready, 1);
    d = dv;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    a = cyc;
    if (churn) d = 8'($urandom); else in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!out_valid && t < 40) begin
        @(negedge clk);
        if (churn) d = 8'($urandom);
        t++;
      end
      chk("valid_timeout", out_valid, 1);
      chk("latency", cyc - a, 4 + 5 * i + stalled);
      chk("out", out, int'(dv) * coef[i]);
      chk("out_idx", out_idx, i);
      chk("out_last", out_last, i == 3);
      if (i == stall_idx) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          if (churn) d = 8'($urandom);
          chk("stall_valid", out_valid, 1);
          chk("stall_out", out, int'(dv) * coef[i]);
          chk("stall_idx", out_idx, i);
        end
        out_ready = 1'b1;
        stalled += stall_n;
      end
      @(negedge clk);
      chk("valid_drop", out_valid, 0);
    end
    chk("in_ready_post", in_ready, 1);
    chk("period", cyc - a, 20 + stalled);
  endtask
  initial begin
    int a, t;
    rst = 1'b0; in_valid = 1'b0; d = '0; out_ready = 1'b0;
    v2 = 1'b0; d2 = '0; or2 = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready2", ir2, 1);
    rst = 1'b1;
    @(negedge clk);
    run_sample(8'd10, -1, 0, 1'b0);
    run_sample(8'd255, -1, 0, 1'b0);
    run_sample(8'd10, 1, 3, 1'b0);
    run_sample(8'h5a, -1, 0, 1'b1);
    run_sample(8'hc3, -1, 0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    d = 8'd10; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst_out", out, 30);
    chk("pre_rst_idx", out_idx, 1);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out", out, 0);
    chk("arst_out_idx", out_idx, 0);
    chk("arst_out_last", out_last, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    run_sample(8'd3, -1, 0, 1'b0);
    repeat (6) run_sample(8'($urandom), int'($urandom_range(0, 4)) - 1, int'($urandom_range(1, 3)), 1'b0);
    d2 = 8'd200; v2 = 1'b1; or2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    a = cyc;
    for (int i = 0; i < 2; i++) begin
      t = 0;
      while (!ov2 && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk("n2_valid_timeout", ov2, 1);
      chk("n2_latency", cyc - a, 4 + 5 * i);
      chk("n2_out", o2, i == 0 ? 0 : 3000);
      chk("n2_idx", oi2, i);
      chk("n2_last", ol2, i == 1);
      @(negedge clk);
      chk("n2_valid_drop", ov2, 0);
    end
    chk("n2_in_ready_post", ir2, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
